// File: rtl/uart_fifo_core_if.sv
// Stream interface between the bus-side register logic and the UART core.
// The master (bus side) pushes TX words and pops RX words; the slave is the UART.
interface uart_fifo_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output rx_ready,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  rx_ready,
        output tx_ready,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/uart_fifo_core.sv
// Full-duplex UART with TX/RX FIFOs, optional parity, sticky error flags and an interrupt.
// Single clock domain with synchronous active-high reset; uart_rx is synchronised internally.

// Synchronous FIFO with first-word fall-through read. A push while full is accepted only
// when a pop happens in the same cycle (the freed slot is reused).
module uart_fifo_core_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_s;
    logic             pop_s;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == (AW+1)'(0));
    assign data_o  = mem_q[rd_ptr_q];
    assign pop_s   = pop_i & ~empty_o;
    assign push_s  = push_i & (~full_o | pop_s);

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_fifo_core_if.slave  bus,
    input  logic             err_clr_i,
    output logic [2:0]       err_status_o,
    output logic             tx_busy_o,
    output logic             interrupt_o,
    input  logic             uart_rx_i,
    output logic             uart_tx_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_WAIT   = 3'd5
    } rx_state_e;

    // Parity bit that accompanies a data word.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
        return (^data) ^ (PARITY_ODD != 0);
    endfunction

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] tx_head_s;
    logic                 tx_full_s, tx_empty_s, tx_pop_s;
    logic [DATA_BITS-1:0] rx_head_s;
    logic                 rx_full_s, rx_empty_s, rx_push_s;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

    uart_fifo_core_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus.tx_valid & ~tx_full_s),
        .data_i  (bus.tx_data),
        .pop_i   (tx_pop_s),
        .data_o  (tx_head_s),
        .full_o  (tx_full_s),
        .empty_o (tx_empty_s)
    );

    uart_fifo_core_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push_s),
        .data_i  (rx_shift_q),
        .pop_i   (bus.rx_ready),
        .data_o  (rx_head_s),
        .full_o  (rx_full_s),
        .empty_o (rx_empty_s)
    );

    assign bus.tx_ready = ~tx_full_s;
    assign bus.rx_valid = ~rx_empty_s;
    assign bus.rx_data  = rx_head_s;

    // ---------------- Transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 uart_tx_q;
    logic                 tx_line_s;
    logic                 tx_baud_end_s;

    assign tx_baud_end_s = (tx_cnt_q == BAUD_LAST);

    // TX state and datapath registers; the pin is registered so it is glitch-free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= CW'(0);
            tx_bit_q   <= BW'(0);
            tx_shift_q <= DATA_BITS'(0);
            tx_par_q   <= 1'b0;
            uart_tx_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            uart_tx_q  <= tx_line_s;
        end
    end

    // TX next state: each bit lasts CLK_DIV cycles; STOP chains straight into START when data waits.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_pop_s) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = CW'(0);
                    tx_shift_d = tx_head_s;
                    tx_par_d   = parity_bit(tx_head_s);
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_baud_end_s) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CW'(0);
                    tx_bit_d   = BW'(0);
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_baud_end_s) begin
                    tx_cnt_d   = CW'(0);
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + BW'(1);
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_PARITY: begin
                if (tx_baud_end_s) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = CW'(0);
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_baud_end_s) begin
                    tx_cnt_d = CW'(0);
                    if (tx_pop_s) begin
                        tx_state_d = TX_START;
                        tx_shift_d = tx_head_s;
                        tx_par_d   = parity_bit(tx_head_s);
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_cnt_d   = CW'(0);
            end
        endcase
    end

    // TX outputs: line level for the current bit and the FIFO pop that loads the next word.
    always_comb begin
        tx_pop_s  = 1'b0;
        tx_line_s = 1'b1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_s = 1'b1;
                tx_pop_s  = ~tx_empty_s;
            end
            TX_START:  tx_line_s = 1'b0;
            TX_DATA:   tx_line_s = tx_shift_q[0];
            TX_PARITY: tx_line_s = tx_par_q;
            TX_STOP: begin
                tx_line_s = 1'b1;
                tx_pop_s  = tx_baud_end_s & ~tx_empty_s;
            end
            default:   tx_line_s = 1'b1;
        endcase
    end

    assign uart_tx_o = uart_tx_q;
    assign tx_busy_o = ~tx_empty_s | (tx_state_q != TX_IDLE);

    // ---------------- Receiver ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [BW-1:0] rx_bit_q, rx_bit_d;
    logic          rx_par_bad_q, rx_par_bad_d;
    logic          rx_sync1_q, rx_sync2_q;
    logic          rx_line_s;
    logic          rx_baud_end_s, rx_half_end_s;
    logic          set_frame_s, set_parity_s, set_overrun_s;
    logic [2:0]    err_q, err_d;

    assign rx_line_s     = rx_sync2_q;
    assign rx_baud_end_s = (rx_cnt_q == BAUD_LAST);
    assign rx_half_end_s = (rx_cnt_q == HALF_LAST);

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= uart_rx_i;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= CW'(0);
            rx_bit_q     <= BW'(0);
            rx_shift_q   <= DATA_BITS'(0);
            rx_par_bad_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_bad_q <= rx_par_bad_d;
        end
    end

    // RX next state: half-bit start check rejects glitches, then one sample per bit at mid-bit.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_bad_d = rx_par_bad_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_line_s) begin
                    rx_state_d   = RX_START;
                    rx_cnt_d     = CW'(0);
                    rx_par_bad_d = 1'b0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_half_end_s) begin
                    rx_cnt_d   = CW'(0);
                    rx_bit_d   = BW'(0);
                    rx_state_d = rx_line_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_baud_end_s) begin
                    rx_cnt_d   = CW'(0);
                    rx_shift_d = {rx_line_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_PARITY: begin
                if (rx_baud_end_s) begin
                    rx_cnt_d     = CW'(0);
                    rx_par_bad_d = rx_line_s ^ parity_bit(rx_shift_q);
                    rx_state_d   = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_baud_end_s) begin
                    rx_cnt_d   = CW'(0);
                    rx_state_d = rx_line_s ? RX_IDLE : RX_WAIT;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_WAIT: begin
                if (rx_line_s) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                rx_cnt_d   = CW'(0);
            end
        endcase
    end

    // RX outputs: at the stop-bit sample either store the word or raise exactly one error.
    always_comb begin
        rx_push_s     = 1'b0;
        set_frame_s   = 1'b0;
        set_parity_s  = 1'b0;
        set_overrun_s = 1'b0;
        if ((rx_state_q == RX_STOP) && rx_baud_end_s) begin
            if (!rx_line_s) begin
                set_frame_s = 1'b1;
            end else if (rx_par_bad_q) begin
                set_parity_s = 1'b1;
            end else if (rx_full_s && !bus.rx_ready) begin
                set_overrun_s = 1'b1;
            end else begin
                rx_push_s = 1'b1;
            end
        end else begin
            rx_push_s = 1'b0;
        end
    end

    // Sticky error flags; a new error in the clearing cycle survives the clear.
    always_comb begin
        if (err_clr_i) begin
            err_d = 3'b000;
        end else begin
            err_d = err_q;
        end
        err_d = err_d | {set_overrun_s, set_parity_s, set_frame_s};
    end

    // Error status register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_status_o = err_q;
    assign interrupt_o  = ~rx_empty_s | (|err_q);
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: dut1 (8N1, CLK_DIV=16, loopback-capable) and dut2 (8E1, CLK_DIV=8).
module tb_uart_fifo_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       lb1, rx1_drv, rx1_line, tx1, err_clr1, busy1, irq1;
    logic [2:0] err1;
    logic       rx2_drv, tx2, err_clr2, busy2, irq2;
    logic [2:0] err2;

    uart_fifo_core_if #(.DATA_BITS(8)) bus1 ();
    uart_fifo_core_if #(.DATA_BITS(8)) bus2 ();

    assign rx1_line = lb1 ? tx1 : rx1_drv;

    uart_fifo_core #(.DATA_BITS(8), .CLK_DIV(16), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1), .err_clr_i(err_clr1), .err_status_o(err1),
        .tx_busy_o(busy1), .interrupt_o(irq1), .uart_rx_i(rx1_line), .uart_tx_o(tx1)
    );

    uart_fifo_core #(.DATA_BITS(8), .CLK_DIV(8), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(bus2), .err_clr_i(err_clr2), .err_status_o(err2),
        .tx_busy_o(busy2), .interrupt_o(irq2), .uart_rx_i(rx2_drv), .uart_tx_o(tx2)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    logic [7:0] words [17];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame into dut2: start, 8 data LSB first, parity p, stop s; 8 cycles per bit.
    task automatic send2(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] fr;
        fr = {s, p, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            rx2_drv = fr[b];
            repeat (8) @(negedge clk);
        end
        rx2_drv = 1'b1;
    endtask

    initial begin
        logic [9:0]  fr10;
        logic [10:0] fr11;
        int          idx;
        bit          ok;

        words = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h12,
                  8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h7E};
        rst = 1'b1;
        bus1.tx_data = 8'h00; bus1.tx_valid = 1'b0; bus1.rx_ready = 1'b0;
        bus2.tx_data = 8'h00; bus2.tx_valid = 1'b0; bus2.rx_ready = 1'b0;
        err_clr1 = 1'b0; err_clr2 = 1'b0;
        lb1 = 1'b1; rx1_drv = 1'b1; rx2_drv = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_uart_tx", tx1, 1);
        check("rst_tx_ready", bus1.tx_ready, 1);
        check("rst_rx_valid", bus1.rx_valid, 0);
        check("rst_err", err1, 0);
        check("rst_busy", busy1, 0);
        check("rst_irq", irq1, 0);
        check("rst_uart_tx2", tx2, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: single 0xA5 frame, exact latency and bit timing
        bus1.tx_data = 8'hA5; bus1.tx_valid = 1'b1;
        @(negedge clk);
        bus1.tx_valid = 1'b0;
        check("t1_lat_edge_n", tx1, 1);
        @(negedge clk);
        check("t1_lat_edge_n1", tx1, 1);
        fr10 = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            check("t1_bit", tx1, fr10[k/16]);
            if (k == 0)   check("t1_busy_start", busy1, 1);
            if (k == 158) check("t1_busy_stop", busy1, 1);
            if (k == 159) check("t1_busy_fall", busy1, 0);
        end
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus1.rx_valid) ok = 1'b1;
        end
        check("t1_rx_seen", ok, 1);
        check("t1_rx_data", bus1.rx_data, 8'hA5);
        check("t1_err", err1, 0);
        check("t1_irq", irq1, 1);
        bus1.rx_ready = 1'b1;
        @(negedge clk);
        bus1.rx_ready = 1'b0;
        check("t1_rx_popped", bus1.rx_valid, 0);
        check("t1_irq_clear", irq1, 0);

        // Test 2: loopback of 16 words
        for (int i = 0; i < 16; i++) begin
            bus1.tx_data = words[i]; bus1.tx_valid = 1'b1;
            @(negedge clk);
        end
        bus1.tx_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (!busy1) ok = 1'b1;
        end
        check("t2_tx_done", ok, 1);
        repeat (40) @(negedge clk);
        check("t2_err", err1, 0);
        check("t2_rx_valid", bus1.rx_valid, 1);
        bus1.rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2_rx_data", bus1.rx_data, words[i]);
            @(negedge clk);
        end
        bus1.rx_ready = 1'b0;
        check("t2_rx_empty", bus1.rx_valid, 0);

        // Tests 3+4: 17 back-to-back pushes, full flag, gapless TX, RX overrun on the 17th
        for (int cyc = 0; cyc <= 2722; cyc++) begin
            if (cyc < 17) begin
                check("t3_ready", bus1.tx_ready, 1);
                bus1.tx_data = words[cyc]; bus1.tx_valid = 1'b1;
            end else if (cyc == 17) begin
                check("t3_full", bus1.tx_ready, 0);
                bus1.tx_data = 8'h11;
            end else if (cyc == 20) begin
                bus1.tx_valid = 1'b0;
            end
            if (cyc >= 11 && ((cyc - 11) % 16) == 0 && ((cyc - 11) / 16) < 170) begin
                idx  = (cyc - 11) / 16;
                fr10 = {1'b1, words[idx/10], 1'b0};
                check("t3_bit", tx1, fr10[idx%10]);
            end
            if (cyc == 2721) check("t3_busy_last", busy1, 1);
            if (cyc == 2722) check("t3_busy_fall", busy1, 0);
            @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check("t4_err_overrun", err1, 3'b100);
        check("t4_irq", irq1, 1);
        check("t4_rx_valid", bus1.rx_valid, 1);
        err_clr1 = 1'b1;
        @(negedge clk);
        err_clr1 = 1'b0;
        check("t4_err_cleared", err1, 0);
        check("t4_irq_held", irq1, 1);
        bus1.rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t4_rx_data", bus1.rx_data, words[i]);
            @(negedge clk);
        end
        bus1.rx_ready = 1'b0;
        check("t4_rx_empty", bus1.rx_valid, 0);
        check("t4_irq_low", irq1, 0);

        // Test 5: parity build (8E1, CLK_DIV=8)
        send2(8'h03, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_par_nopush", bus2.rx_valid, 0);
        check("t5_par_err", err2, 3'b010);
        check("t5_par_irq", irq2, 1);
        send2(8'h03, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_good_valid", bus2.rx_valid, 1);
        check("t5_good_data", bus2.rx_data, 8'h03);
        check("t5_err_sticky", err2, 3'b010);
        bus2.rx_ready = 1'b1;
        @(negedge clk);
        bus2.rx_ready = 1'b0;
        err_clr2 = 1'b1;
        @(negedge clk);
        err_clr2 = 1'b0;
        check("t5_err_clr", err2, 0);
        check("t5_irq_low", irq2, 0);
        send2(8'h5A, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("t5_frame_err", err2, 3'b001);
        check("t5_frame_nopush", bus2.rx_valid, 0);
        send2(8'h81, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_recover_valid", bus2.rx_valid, 1);
        check("t5_recover_data", bus2.rx_data, 8'h81);
        bus2.rx_ready = 1'b1;
        @(negedge clk);
        bus2.rx_ready = 1'b0;
        bus2.tx_data = 8'h07; bus2.tx_valid = 1'b1;
        fr11 = {1'b1, 1'b1, 8'h07, 1'b0};
        for (int cyc = 0; cyc <= 90; cyc++) begin
            if (cyc == 1) bus2.tx_valid = 1'b0;
            if (cyc >= 7 && ((cyc - 7) % 8) == 0 && ((cyc - 7) / 8) < 11) begin
                idx = (cyc - 7) / 8;
                check("t5_tx_bit", tx2, fr11[idx]);
            end
            if (cyc == 90) check("t5_tx_busy_fall", busy2, 0);
            @(negedge clk);
        end

        // Test 6: glitch rejection and reset mid-frame
        lb1 = 1'b0; rx1_drv = 1'b1;
        @(negedge clk);
        rx1_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx1_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_glitch_valid", bus1.rx_valid, 0);
        check("t6_glitch_err", err1, 0);
        check("t6_glitch_irq", irq1, 0);
        for (int i = 0; i < 3; i++) begin
            bus1.tx_data = 8'h00; bus1.tx_valid = 1'b1;
            @(negedge clk);
        end
        bus1.tx_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("t6_pre_rst_tx", tx1, 0);
        check("t6_pre_rst_busy", busy1, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_tx", tx1, 1);
        check("t6_rst_ready", bus1.tx_ready, 1);
        check("t6_rst_busy", busy1, 0);
        check("t6_rst_rx_valid", bus1.rx_valid, 0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("t6_no_resume_tx", tx1, 1);
        check("t6_no_resume_busy", busy1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
